// File: rtl/inst_prefetch_buf_if.sv
// rtl/inst_prefetch_buf_if.sv - SRAM-like instruction fetch port between prefetch buffer and memory
interface inst_prefetch_buf_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_rdata,
        input  inst_addr_ok,
        input  inst_data_ok
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_rdata,
        output inst_addr_ok,
        output inst_data_ok
    );
endinterface

// File: rtl/inst_prefetch_buf.sv
// rtl/inst_prefetch_buf.sv - DEPTH-entry in-order instruction prefetch queue with redirect flush and AdEL
// Optional same-cycle response bypass to decode when FETCH_BYPASS_EN is defined.
module inst_prefetch_buf #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    inst_prefetch_buf_if.master      ibus,
    output logic                     valid_o,
    output logic [31:0]              pc_o,
    output logic [31:0]              inst_o,
    output logic                     exc_o,
    output logic [4:0]               exccode_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [31:0]    fpc;
    logic [CW-1:0]  cnt;
    logic [OW-1:0]  pend;
    logic [OW-1:0]  drop;
    logic           halt;
    logic [AW-1:0]  rd;
    logic [AW-1:0]  wr;

    logic [31:0]    pc_mem   [DEPTH];
    logic [31:0]    inst_mem [DEPTH];
    logic [DEPTH-1:0] exc_mem;

    // Issued-address FIFO; its occupancy always equals pend, stale entries included.
    logic [31:0]    afifo [MAX_OUT];
    logic [QW-1:0]  a_rd;
    logic [QW-1:0]  a_wr;

    logic           aligned;
    logic [OW-1:0]  inflight;
    logic           credit_ok;
    logic           req;
    logic           acc;
    logic           dok;
    logic           live;
    logic           byp_valid;
    logic           byp_take;
    logic           pop;
    logic           push_data;
    logic           exc_push;
    logic           push;

    function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUT - 1)) ? '0 : p + QW'(1);
    endfunction

    always_comb begin
        aligned   = (fpc[1:0] == 2'b00);
        inflight  = pend - drop;
        credit_ok = (({{(32-CW){1'b0}}, cnt} + {{(32-OW){1'b0}}, inflight}) < 32'(DEPTH));
        req       = resetn && !halt && !redirect && aligned && credit_ok && (pend < OW'(MAX_OUT));
        acc       = req && ibus.inst_addr_ok;
        dok       = ibus.inst_data_ok;
        live      = dok && (drop == '0);
    end

`ifdef FETCH_BYPASS_EN
    assign byp_valid = live && (cnt == '0) && !redirect;
    assign byp_take  = byp_valid && ready_i;
`else
    assign byp_valid = 1'b0;
    assign byp_take  = 1'b0;
`endif

    always_comb begin
        pop       = (cnt != '0) && ready_i && !redirect;
        push_data = live && !byp_take;
        // AdEL entry waits until every live response has landed so order is preserved.
        exc_push  = !halt && !aligned && (pend == drop) && (cnt < CW'(DEPTH)) && !dok && !redirect;
        push      = (push_data || exc_push) && !redirect;
    end

    assign ibus.inst_req  = req;
    assign ibus.inst_addr = fpc;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fpc  <= RESET_PC;
            cnt  <= '0;
            pend <= '0;
            drop <= '0;
            halt <= 1'b0;
            rd   <= '0;
            wr   <= '0;
        end else begin
            pend <= pend + OW'(acc) - OW'(dok);
            if (redirect) begin
                fpc  <= redirect_pc;
                cnt  <= '0;
                rd   <= wr;
                halt <= 1'b0;
                drop <= pend + OW'(acc) - OW'(dok);
            end else begin
                if (acc)
                    fpc <= fpc + 32'd4;
                if (dok && (drop != '0))
                    drop <= drop - OW'(1);
                if (push)
                    wr <= wr + AW'(1);
                if (pop)
                    rd <= rd + AW'(1);
                cnt <= cnt + CW'(push) - CW'(pop);
                if (exc_push)
                    halt <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_rd <= '0;
            a_wr <= '0;
        end else begin
            if (acc)
                a_wr <= q_next(a_wr);
            if (dok)
                a_rd <= q_next(a_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (acc)
            afifo[a_wr] <= fpc;
    end

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            pc_mem[wr]   <= exc_push ? fpc : afifo[a_rd];
            inst_mem[wr] <= exc_push ? 32'h0 : ibus.inst_rdata;
            exc_mem[wr]  <= exc_push;
        end
    end

    always_comb begin
        valid_o   = 1'b0;
        pc_o      = 32'h0;
        inst_o    = 32'h0;
        exc_o     = 1'b0;
        exccode_o = 5'h00;
        if (cnt != '0) begin
            valid_o = 1'b1;
            pc_o    = pc_mem[rd];
            inst_o  = inst_mem[rd];
            exc_o   = exc_mem[rd];
        end else if (byp_valid) begin
            valid_o = 1'b1;
            pc_o    = afifo[a_rd];
            inst_o  = ibus.inst_rdata;
        end
        if (exc_o)
            exccode_o = 5'h04;
    end

    assign count_o = cnt;

endmodule
